// File: rtl/pipe_fp_add_if.sv
// Operand/result handshake bundle for pipe_fp_add.
// The master drives the operand pair and out_ready; the slave (the adder) drives results.
interface pipe_fp_add_if;
  logic        in_valid;
  logic        in_ready;
  logic        xs;
  logic [7:0]  xe;
  logic [22:0] xm;
  logic        ys;
  logic [7:0]  ye;
  logic [22:0] ym;
  logic        out_valid;
  logic        out_ready;
  logic        out_outs;
  logic [7:0]  out_oute;
  logic [22:0] out_outm;

  modport master (
    output in_valid, xs, xe, xm, ys, ye, ym, out_ready,
    input  in_ready, out_valid, out_outs, out_oute, out_outm
  );

  modport slave (
    input  in_valid, xs, xe, xm, ys, ye, ym, out_ready,
    output in_ready, out_valid, out_outs, out_oute, out_outm
  );
endinterface

// File: rtl/pipe_fp_add.sv
// Three-stage FP32 adder: compare/swap, align/add, normalize/pack; denormals flush to zero.
// Define FP_SPECIAL_EN for round-to-nearest-even and inf/NaN handling; otherwise it truncates.
module pipe_fp_add #(
  parameter int SHIFT_MAX  = 27,
  parameter int PIPE_DEPTH = 3
) (
  input logic          clk,
  input logic          rst,
  pipe_fp_add_if.slave bus
);
  localparam int         LAST      = PIPE_DEPTH - 1;
  localparam logic [7:0] SHIFT_SAT = 8'(SHIFT_MAX);

  logic                  advance;
  logic [PIPE_DEPTH-1:0] vld_q;

  assign advance       = !vld_q[LAST] || bus.out_ready;
  assign bus.in_ready  = advance;
  assign bus.out_valid = vld_q[LAST];

  // The whole pipe moves together; a stall freezes every stage.
  genvar gi;
  generate
    for (gi = 0; gi < PIPE_DEPTH; gi++) begin : g_vld
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (rst)          vld_q[gi] <= 1'b0;
          else if (advance) vld_q[gi] <= bus.in_valid;
        end
      end else begin : g_tail
        always_ff @(posedge clk) begin
          if (rst)          vld_q[gi] <= 1'b0;
          else if (advance) vld_q[gi] <= vld_q[gi-1];
        end
      end
    end
  endgenerate

  // ---------------- stage 1: compare / swap ----------------
  logic        a_big;
  logic        s1_sign_d, s1_sub_d, s1_byp_d, s1_byp_s_d;
  logic [7:0]  s1_e_d, s1_d_d, s1_byp_e_d;
  logic [23:0] s1_big_m_d, s1_small_m_d;
  logic [22:0] s1_byp_m_d;
  logic        s1_sign_q, s1_sub_q, s1_byp_q, s1_byp_s_q;
  logic [7:0]  s1_e_q, s1_d_q, s1_byp_e_q;
  logic [23:0] s1_big_m_q, s1_small_m_q;
  logic [22:0] s1_byp_m_q;
`ifdef FP_SPECIAL_EN
  logic x_inf, y_inf, x_nan, y_nan;
`endif

  always_comb begin
    a_big        = {bus.xe, bus.xm} >= {bus.ye, bus.ym};
    s1_sign_d    = a_big ? bus.xs : bus.ys;
    s1_sub_d     = bus.xs ^ bus.ys;
    s1_e_d       = a_big ? bus.xe : bus.ye;
    s1_d_d       = a_big ? (bus.xe - bus.ye) : (bus.ye - bus.xe);
    s1_big_m_d   = {1'b1, a_big ? bus.xm : bus.ym};
    s1_small_m_d = {1'b1, a_big ? bus.ym : bus.xm};
    s1_byp_d     = 1'b1;
    s1_byp_s_d   = bus.xs & bus.ys;
    s1_byp_e_d   = 8'd0;
    s1_byp_m_d   = 23'd0;
    if (bus.xe == 8'd0 && bus.ye == 8'd0) begin
      s1_byp_d = 1'b1;
    end else if (bus.xe == 8'd0) begin
      s1_byp_s_d = bus.ys;
      s1_byp_e_d = bus.ye;
      s1_byp_m_d = bus.ym;
    end else if (bus.ye == 8'd0) begin
      s1_byp_s_d = bus.xs;
      s1_byp_e_d = bus.xe;
      s1_byp_m_d = bus.xm;
    end else begin
      s1_byp_d = 1'b0;
    end
`ifdef FP_SPECIAL_EN
    x_inf = (bus.xe == 8'hFF) && (bus.xm == 23'd0);
    y_inf = (bus.ye == 8'hFF) && (bus.ym == 23'd0);
    x_nan = (bus.xe == 8'hFF) && (bus.xm != 23'd0);
    y_nan = (bus.ye == 8'hFF) && (bus.ym != 23'd0);
    if (x_nan || y_nan || (x_inf && y_inf && (bus.xs != bus.ys))) begin
      s1_byp_d   = 1'b1;
      s1_byp_s_d = 1'b0;
      s1_byp_e_d = 8'hFF;
      s1_byp_m_d = 23'h400000;
    end else if (x_inf) begin
      s1_byp_d   = 1'b1;
      s1_byp_s_d = bus.xs;
      s1_byp_e_d = 8'hFF;
      s1_byp_m_d = 23'd0;
    end else if (y_inf) begin
      s1_byp_d   = 1'b1;
      s1_byp_s_d = bus.ys;
      s1_byp_e_d = 8'hFF;
      s1_byp_m_d = 23'd0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_sign_q    <= 1'b0;
      s1_sub_q     <= 1'b0;
      s1_e_q       <= 8'd0;
      s1_d_q       <= 8'd0;
      s1_big_m_q   <= 24'd0;
      s1_small_m_q <= 24'd0;
      s1_byp_q     <= 1'b0;
      s1_byp_s_q   <= 1'b0;
      s1_byp_e_q   <= 8'd0;
      s1_byp_m_q   <= 23'd0;
    end else if (advance && bus.in_valid) begin
      s1_sign_q    <= s1_sign_d;
      s1_sub_q     <= s1_sub_d;
      s1_e_q       <= s1_e_d;
      s1_d_q       <= s1_d_d;
      s1_big_m_q   <= s1_big_m_d;
      s1_small_m_q <= s1_small_m_d;
      s1_byp_q     <= s1_byp_d;
      s1_byp_s_q   <= s1_byp_s_d;
      s1_byp_e_q   <= s1_byp_e_d;
      s1_byp_m_q   <= s1_byp_m_d;
    end
  end

  // ---------------- stage 2: align / add ----------------
  logic [7:0]  shift_amt;
  logic [26:0] small_ext, small_shr;
  logic        sticky;
  logic [27:0] s2_sum_d;
  logic        s2_sign_q, s2_byp_q, s2_byp_s_q;
  logic [7:0]  s2_e_q, s2_byp_e_q;
  logic [27:0] s2_sum_q;
  logic [22:0] s2_byp_m_q;

  always_comb begin
    shift_amt = (s1_d_q > SHIFT_SAT) ? SHIFT_SAT : s1_d_q;
    small_ext = {s1_small_m_q, 3'b000};
    small_shr = small_ext >> shift_amt;
    sticky    = |(small_ext & ~({27{1'b1}} << shift_amt));
    if (s1_sub_q)
      s2_sum_d = {1'b0, s1_big_m_q, 3'b000} - {1'b0, small_shr[26:1], small_shr[0] | sticky};
    else
      s2_sum_d = {1'b0, s1_big_m_q, 3'b000} + {1'b0, small_shr[26:1], small_shr[0] | sticky};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_sign_q  <= 1'b0;
      s2_e_q     <= 8'd0;
      s2_sum_q   <= 28'd0;
      s2_byp_q   <= 1'b0;
      s2_byp_s_q <= 1'b0;
      s2_byp_e_q <= 8'd0;
      s2_byp_m_q <= 23'd0;
    end else if (advance && vld_q[0]) begin
      s2_sign_q  <= s1_sign_q;
      s2_e_q     <= s1_e_q;
      s2_sum_q   <= s2_sum_d;
      s2_byp_q   <= s1_byp_q;
      s2_byp_s_q <= s1_byp_s_q;
      s2_byp_e_q <= s1_byp_e_q;
      s2_byp_m_q <= s1_byp_m_q;
    end
  end

  // ---------------- stage 3: normalize / pack ----------------
  logic [4:0]        lz;
  logic              lz_found;
  logic [26:0]       norm;
  logic signed [9:0] exp_norm, exp_rnd;
  logic [22:0]       frac;
  logic              out_s_d, out_s_q;
  logic [7:0]        out_e_d, out_e_q;
  logic [22:0]       out_m_d, out_m_q;
`ifdef FP_SPECIAL_EN
  logic              round_up;
  logic [24:0]       mant_rnd;
`endif

  always_comb begin
    lz       = 5'd0;
    lz_found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!lz_found && s2_sum_q[i]) begin
        lz       = 5'(26 - i);
        lz_found = 1'b1;
      end
    end
    if (s2_sum_q[27]) begin
      norm     = {s2_sum_q[27:2], s2_sum_q[1] | s2_sum_q[0]};
      exp_norm = $signed({2'b00, s2_e_q}) + 10'sd1;
    end else begin
      norm     = s2_sum_q[26:0] << lz;
      exp_norm = $signed({2'b00, s2_e_q}) - $signed({5'b00000, lz});
    end
`ifdef FP_SPECIAL_EN
    round_up = norm[2] & (norm[3] | norm[1] | norm[0]);
    mant_rnd = {1'b0, norm[26:3]} + {24'd0, round_up};
    if (mant_rnd[24]) begin
      frac    = mant_rnd[23:1];
      exp_rnd = exp_norm + 10'sd1;
    end else begin
      frac    = mant_rnd[22:0];
      exp_rnd = exp_norm;
    end
`else
    frac    = 23'(norm >> 3);
    exp_rnd = exp_norm;
`endif
    out_s_d = s2_sign_q;
    out_e_d = exp_rnd[7:0];
    out_m_d = frac;
    if (s2_byp_q) begin
      out_s_d = s2_byp_s_q;
      out_e_d = s2_byp_e_q;
      out_m_d = s2_byp_m_q;
    end else if (s2_sum_q == 28'd0) begin
      out_s_d = 1'b0;
      out_e_d = 8'd0;
      out_m_d = 23'd0;
    end else if (exp_rnd >= 10'sd255) begin
      out_e_d = 8'hFF;
      out_m_d = 23'd0;
    end else if (exp_rnd <= 10'sd0) begin
      out_s_d = 1'b0;
      out_e_d = 8'd0;
      out_m_d = 23'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_s_q <= 1'b0;
      out_e_q <= 8'd0;
      out_m_q <= 23'd0;
    end else if (advance && vld_q[1]) begin
      out_s_q <= out_s_d;
      out_e_q <= out_e_d;
      out_m_q <= out_m_d;
    end
  end

  assign bus.out_outs = out_s_q;
  assign bus.out_oute = out_e_q;
  assign bus.out_outm = out_m_q;
endmodule

// File: tb/tb_pipe_fp_add.sv
// Directed-vector bench for pipe_fp_add: arithmetic cases, latency, stall/backpressure and mid-flight reset.
module tb_pipe_fp_add;
  logic clk = 1'b0;
  logic rst;
  int   n_vec  = 0;
  int   n_miss = 0;

  pipe_fp_add_if bus ();

  pipe_fp_add dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        xs;
    logic [7:0]  xe;
    logic [22:0] xm;
    logic        ys;
    logic [7:0]  ye;
    logic [22:0] ym;
    logic        es;
    logic [7:0]  ee;
    logic [22:0] em;
  } vec_t;

  vec_t sv [4];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  task automatic drive_pair(input vec_t v);
    bus.xs = v.xs;
    bus.xe = v.xe;
    bus.xm = v.xm;
    bus.ys = v.ys;
    bus.ye = v.ye;
    bus.ym = v.ym;
  endtask

  // One operand pair through an otherwise idle pipe with out_ready held high.
  task automatic run_vec(input string tag, input vec_t v);
    int lat;
    @(negedge clk);
    drive_pair(v);
    bus.in_valid = 1'b1;
    #1;
    check_val({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check_val({tag, "_latency"}, 32'(lat), 32'd3);
    check_val({tag, "_s"}, 32'(bus.out_outs), 32'(v.es));
    check_val({tag, "_e"}, 32'(bus.out_oute), 32'(v.ee));
    check_val({tag, "_m"}, 32'(bus.out_outm), 32'(v.em));
    $display("vec %s: s=%0d e=%0d m=%06h lat=%0d", tag, bus.out_outs, bus.out_oute, bus.out_outm, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tx;
    int rx;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.xs = 1'b0; bus.xe = 8'd0; bus.xm = 23'd0;
    bus.ys = 1'b0; bus.ye = 8'd0; bus.ym = 23'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_outs", 32'(bus.out_outs), 32'd0);
    check_val("rst_oute", 32'(bus.out_oute), 32'd0);
    check_val("rst_outm", 32'(bus.out_outm), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Arithmetic vectors: {xs,xe,xm, ys,ye,ym, expected s,e,m}
    run_vec("one_plus_one",  '{1'b0, 8'd127, 23'd0, 1'b0, 8'd127, 23'd0, 1'b0, 8'd128, 23'd0});
    run_vec("cancel",        '{1'b0, 8'd127, 23'h400000, 1'b1, 8'd127, 23'h400000, 1'b0, 8'd0, 23'd0});
    run_vec("sticky_only",   '{1'b0, 8'd127, 23'd0, 1'b0, 8'd97, 23'd0, 1'b0, 8'd127, 23'd0});
    run_vec("overflow",      '{1'b0, 8'd254, 23'h7FFFFF, 1'b0, 8'd254, 23'h7FFFFF, 1'b0, 8'd255, 23'd0});
    run_vec("underflow",     '{1'b0, 8'd1, 23'd1, 1'b1, 8'd1, 23'd0, 1'b0, 8'd0, 23'd0});
    run_vec("two_minus_one", '{1'b0, 8'd128, 23'd0, 1'b1, 8'd127, 23'd0, 1'b0, 8'd127, 23'd0});
    run_vec("b_bigger",      '{1'b0, 8'd127, 23'd0, 1'b1, 8'd128, 23'h400000, 1'b1, 8'd128, 23'd0});
    run_vec("zero_pass",     '{1'b0, 8'd0, 23'h000123, 1'b1, 8'd130, 23'h012345, 1'b1, 8'd130, 23'h012345});
    run_vec("neg_zeros",     '{1'b1, 8'd0, 23'd0, 1'b1, 8'd0, 23'd5, 1'b1, 8'd0, 23'd0});
`ifdef FP_SPECIAL_EN
    run_vec("round_even",    '{1'b0, 8'd127, 23'd0, 1'b0, 8'd104, 23'h400000, 1'b0, 8'd127, 23'd2});
    run_vec("inf_minus_inf", '{1'b0, 8'd255, 23'd0, 1'b1, 8'd255, 23'd0, 1'b0, 8'd255, 23'h400000});
`else
    run_vec("truncate",      '{1'b0, 8'd127, 23'd0, 1'b0, 8'd104, 23'h400000, 1'b0, 8'd127, 23'd1});
`endif

    // Back-to-back issue with a 5-cycle consumer stall starting when the first result appears.
    sv[0] = '{1'b0, 8'd127, 23'd0, 1'b0, 8'd127, 23'd0, 1'b0, 8'd128, 23'd0};
    sv[1] = '{1'b0, 8'd128, 23'd0, 1'b1, 8'd127, 23'd0, 1'b0, 8'd127, 23'd0};
    sv[2] = '{1'b0, 8'd127, 23'd0, 1'b1, 8'd128, 23'h400000, 1'b1, 8'd128, 23'd0};
    sv[3] = '{1'b0, 8'd127, 23'h400000, 1'b0, 8'd127, 23'h400000, 1'b0, 8'd128, 23'h400000};
    tx = 0;
    rx = 0;
    for (int c = 0; c < 40 && rx < 4; c++) begin
      @(negedge clk);
      bus.out_ready = !(c >= 3 && c < 8);
      if (tx < 4) begin
        drive_pair(sv[tx]);
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (c >= 3 && c < 8) begin
        check_val("stall_in_ready", 32'(bus.in_ready), 32'd0);
        check_val("stall_out_valid", 32'(bus.out_valid), 32'd1);
        check_val("stall_hold_e", 32'(bus.out_oute), 32'(sv[rx].ee));
        check_val("stall_hold_s", 32'(bus.out_outs), 32'(sv[rx].es));
      end
      if (bus.out_valid && bus.out_ready) begin
        check_val("stall_res_s", 32'(bus.out_outs), 32'(sv[rx].es));
        check_val("stall_res_e", 32'(bus.out_oute), 32'(sv[rx].ee));
        check_val("stall_res_m", 32'(bus.out_outm), 32'(sv[rx].em));
        $display("stall result %0d at cycle %0d: s=%0d e=%0d m=%06h", rx, c, bus.out_outs, bus.out_oute, bus.out_outm);
        rx++;
      end
      if (bus.in_valid && bus.in_ready) tx++;
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check_val("stall_rx_count", 32'(rx), 32'd4);
    check_val("stall_tx_count", 32'(tx), 32'd4);
    check_val("stall_no_dup", 32'(bus.out_valid), 32'd0);

    // Reset with two pairs in flight: nothing may emerge afterwards.
    @(negedge clk);
    drive_pair(sv[0]);
    bus.in_valid = 1'b1;
    @(negedge clk);
    drive_pair(sv[3]);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      check_val("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      check_val("midrst_oute", 32'(bus.out_oute), 32'd0);
      check_val("midrst_outm", 32'(bus.out_outm), 32'd0);
      check_val("midrst_outs", 32'(bus.out_outs), 32'd0);
      @(negedge clk);
      #1;
    end
    $display("mid-flight reset: outputs stayed idle for 4 cycles");
    run_vec("after_reset",   '{1'b0, 8'd127, 23'h400000, 1'b0, 8'd127, 23'h400000, 1'b0, 8'd128, 23'h400000});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
